// File: rtl/array_cmd_sequencer.sv
// array_cmd_sequencer: issues LOAD / MAC / CAM command sequences to a memory
// array over a valid/ready command channel.
// Optional feature: define ARRAY_SEQ_CAM_EN to build the CAM state; without it
// mode=10 is rejected as an illegal start.
module array_cmd_sequencer #(
   parameter int N_BANK = 16,
   parameter int N_ROW  = 4,
   parameter int COL_W  = 3,
   parameter int DATA_W = 16,
   parameter int ADDR_W = $clog2(N_BANK) + $clog2(N_ROW) + COL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] seed,
   input  logic [7:0]        mac_len,
   input  logic [DATA_W-1:0] op_data,
   input  logic              abort,
   input  logic              cmd_ready,
   output logic              cmd_valid,
   output logic [1:0]        op_code,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data_bank,
   output logic [DATA_W-1:0] data_in,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int BW    = $clog2(N_BANK);
   localparam int RW    = $clog2(N_ROW);
   localparam int IDX_W = BW + RW;
   // One counter serves both the LOAD bank/row walk and the MAC command count.
   localparam int CNT_W = (IDX_W > 8) ? IDX_W : 8;

   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(N_BANK * N_ROW - 1);
   localparam logic [COL_W-1:0] COL_ZERO  = '0;
   localparam logic [BW-1:0]    BANK_ZERO = '0;

   localparam logic [1:0] OP_MAC   = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_CAM   = 2'b10;
   localparam logic [1:0] OP_NOP   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MAC,
      S_DONE
`ifdef ARRAY_SEQ_CAM_EN
      , S_CAM
`endif
   } state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [DATA_W-1:0]   seed_q, op_data_q;
   logic [7:0]          mac_len_q;
   logic                err_q, err_d;
   logic                latch;
   logic                xfer;
   logic [BW-1:0]       bank_idx;
   logic [RW-1:0]       row_idx;

   assign xfer     = cmd_valid && cmd_ready;
   assign bank_idx = cnt[IDX_W-1:RW];
   assign row_idx  = cnt[RW-1:0];

   // State, counter, error pulse and latched sequence parameters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         err_q     <= 1'b0;
         seed_q    <= '0;
         op_data_q <= '0;
         mac_len_q <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         err_q <= err_d;
         if (latch) begin
            seed_q    <= seed;
            op_data_q <= op_data;
            mac_len_q <= mac_len;
         end
      end
   end

   // Next-state logic: start decode in IDLE, advance on each transfer, abort last.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      err_d   = 1'b0;
      latch   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               cnt_d = '0;
               case (mode)
                  2'b00: begin
                     latch   = 1'b1;
                     state_d = (mac_len == 8'd0) ? S_DONE : S_MAC;
                  end
                  2'b01: begin
                     latch   = 1'b1;
                     state_d = S_LOAD;
                  end
`ifdef ARRAY_SEQ_CAM_EN
                  2'b10: begin
                     latch   = 1'b1;
                     state_d = S_CAM;
                  end
`endif
                  default: err_d = 1'b1;
               endcase
            end
         end
         S_LOAD: begin
            if (xfer) begin
               if (cnt == LOAD_LAST) state_d = S_DONE;
               else                  cnt_d   = cnt + CNT_W'(1);
            end
         end
         S_MAC: begin
            if (xfer) begin
               if (cnt == CNT_W'(mac_len_q - 8'd1)) state_d = S_DONE;
               else                                 cnt_d   = cnt + CNT_W'(1);
            end
         end
`ifdef ARRAY_SEQ_CAM_EN
         S_CAM: begin
            if (xfer) state_d = S_DONE;
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      // Abort wins over everything; a transfer in this cycle has already happened.
      if (state != S_IDLE && abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   // Command outputs decoded from registered state so they hold under back-pressure.
   always_comb begin
      cmd_valid = 1'b0;
      op_code   = OP_NOP;
      addr      = '0;
      data_bank = '0;
      data_in   = '0;
      case (state)
         S_LOAD: begin
            cmd_valid = 1'b1;
            op_code   = OP_WRITE;
            addr      = ADDR_W'({bank_idx, row_idx, COL_ZERO});
            data_bank = seed_q + DATA_W'(bank_idx) + DATA_W'(row_idx);
         end
         S_MAC: begin
            cmd_valid = 1'b1;
            op_code   = OP_MAC;
            addr      = ADDR_W'({BANK_ZERO, row_idx, COL_ZERO});
            data_bank = seed_q;
            data_in   = op_data_q;
         end
`ifdef ARRAY_SEQ_CAM_EN
         S_CAM: begin
            cmd_valid = 1'b1;
            op_code   = OP_CAM;
            data_bank = seed_q;
            data_in   = op_data_q;
         end
`endif
         default: ;
      endcase
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);
   assign err  = err_q;

endmodule

// File: tb/tb_array_cmd_sequencer.sv
// Directed self-checking bench for array_cmd_sequencer (default parameters).
// Covers the CAM path when ARRAY_SEQ_CAM_EN is defined, else its rejection.
module tb_array_cmd_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  mode;
   logic [15:0] seed;
   logic [7:0]  mac_len;
   logic [15:0] op_data;
   logic        abort;
   logic        cmd_ready;
   logic        cmd_valid;
   logic [1:0]  op_code;
   logic [8:0]  addr;
   logic [15:0] data_bank;
   logic [15:0] data_in;
   logic        busy;
   logic        done;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   array_cmd_sequencer #(
      .N_BANK(16),
      .N_ROW (4),
      .COL_W (3),
      .DATA_W(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mode     (mode),
      .seed     (seed),
      .mac_len  (mac_len),
      .op_data  (op_data),
      .abort    (abort),
      .cmd_ready(cmd_ready),
      .cmd_valid(cmd_valid),
      .op_code  (op_code),
      .addr     (addr),
      .data_bank(data_bank),
      .data_in  (data_in),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start     = 1'b0;
      mode      = 2'b00;
      seed      = '0;
      mac_len   = '0;
      op_data   = '0;
      abort     = 1'b0;
      cmd_ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #2;
      n_cmp++;
      if ({cmd_valid, op_code, addr, data_bank, data_in, busy, done, err} !==
          {1'b0, 2'b11, 9'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_outputs: got v=%b op=%b a=%h db=%h di=%h busy=%b done=%b err=%b expected idle NOP",
                  cmd_valid, op_code, addr, data_bank, data_in, busy, done, err);
      end
      step();
      step();
      rst = 1'b0;
      step();
      n_cmp++;
      if ({cmd_valid, op_code, busy} !== {1'b0, 2'b11, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_release: got v=%b op=%b busy=%b expected 0 11 0", cmd_valid, op_code, busy);
      end
   endtask

   task automatic test_load();
      int idx = 0;
      int done_cyc = -1;
      logic [8:0]  ea;
      logic [15:0] ed;
      mode = 2'b01; seed = 16'h0000; cmd_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         if (done) begin
            done_cyc = c;
            break;
         end
         if (cmd_valid) begin
            ea = {4'(idx / 4), 2'(idx % 4), 3'd0};
            ed = 16'(idx / 4 + idx % 4);
            n_cmp++;
            if ({op_code, addr, data_bank, data_in} !== {2'b01, ea, ed, 16'h0000}) begin
               n_bad++;
               $display("FAIL load_cmd[%0d]: got op=%b a=%h db=%h di=%h expected op=01 a=%h db=%h di=0000",
                        idx, op_code, addr, data_bank, data_in, ea, ed);
            end
            idx++;
         end
         step();
      end
      n_cmp++;
      if (idx !== 64) begin
         n_bad++;
         $display("FAIL load_count: got %0d expected 64", idx);
      end
      n_cmp++;
      if (done_cyc !== 65) begin
         n_bad++;
         $display("FAIL load_done_cycle: got %0d expected 65", done_cyc);
      end
      step();
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_bad++;
         $display("FAIL load_back_idle: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_mac();
      int idx = 0;
      int done_cyc = -1;
      logic [8:0] ea;
      mode = 2'b00; seed = 16'h0010; mac_len = 8'd6; op_data = 16'hF0FF;
      cmd_ready = 1'b1; start = 1'b1;
      step();
      // Inputs changing and a stray start mid-sequence must have no effect.
      seed = 16'hAAAA; op_data = 16'h1234; mac_len = 8'd2; mode = 2'b01;
      for (int c = 1; c <= 20; c++) begin
         start = (c == 3);
         if (done) begin
            done_cyc = c;
            break;
         end
         if (cmd_valid) begin
            ea = {4'd0, 2'(idx % 4), 3'd0};
            n_cmp++;
            if ({op_code, addr, data_bank, data_in} !== {2'b00, ea, 16'h0010, 16'hF0FF}) begin
               n_bad++;
               $display("FAIL mac_cmd[%0d]: got op=%b a=%h db=%h di=%h expected op=00 a=%h db=0010 di=f0ff",
                        idx, op_code, addr, data_bank, data_in, ea);
            end
            idx++;
         end
         step();
      end
      start = 1'b0;
      n_cmp++;
      if (idx !== 6) begin
         n_bad++;
         $display("FAIL mac_count: got %0d expected 6", idx);
      end
      n_cmp++;
      if (done_cyc !== 7) begin
         n_bad++;
         $display("FAIL mac_done_cycle: got %0d expected 7", done_cyc);
      end
      step();
      step();
   endtask

   task automatic test_backpressure();
      // Per cycle after start: ready, expected valid, expected row, expected done.
      logic [0:7] rdy_t  = 8'b00101100;
      logic [0:7] val_t  = 8'b11111100;
      logic [0:7] done_t = 8'b00000010;
      logic [1:0] row_t [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0};
      logic [8:0] ea;
      mode = 2'b00; seed = 16'h1234; mac_len = 8'd3; op_data = 16'h5555;
      cmd_ready = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 8; c++) begin
         cmd_ready = rdy_t[c];
         ea = val_t[c] ? {4'd0, row_t[c], 3'd0} : 9'd0;
         n_cmp++;
         if ({cmd_valid, done, addr} !== {val_t[c], done_t[c], ea}) begin
            n_bad++;
            $display("FAIL bp_cycle[%0d]: got v=%b done=%b a=%h expected v=%b done=%b a=%h",
                     c + 1, cmd_valid, done, addr, val_t[c], done_t[c], ea);
         end
         step();
      end
      cmd_ready = 1'b0;
   endtask

   task automatic test_cam();
`ifdef ARRAY_SEQ_CAM_EN
      mode = 2'b10; seed = 16'h000F; op_data = 16'hFFFF; cmd_ready = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         cmd_ready = (c == 4);
         n_cmp++;
         if ({cmd_valid, op_code, addr, data_bank, data_in} !== {1'b1, 2'b10, 9'd0, 16'h000F, 16'hFFFF}) begin
            n_bad++;
            $display("FAIL cam_cmd[%0d]: got v=%b op=%b a=%h db=%h di=%h expected 1 10 000 000f ffff",
                     c, cmd_valid, op_code, addr, data_bank, data_in);
         end
         step();
      end
      cmd_ready = 1'b0;
      n_cmp++;
      if ({done, cmd_valid} !== 2'b10) begin
         n_bad++;
         $display("FAIL cam_done: got done=%b v=%b expected 1 0", done, cmd_valid);
      end
      step();
`else
      mode = 2'b10; seed = 16'h000F; op_data = 16'hFFFF; cmd_ready = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      n_cmp++;
      if ({err, cmd_valid, busy} !== 3'b100) begin
         n_bad++;
         $display("FAIL cam_disabled_err: got err=%b v=%b busy=%b expected 1 0 0", err, cmd_valid, busy);
      end
      step();
      n_cmp++;
      if ({err, cmd_valid, busy} !== 3'b000) begin
         n_bad++;
         $display("FAIL cam_disabled_after: got err=%b v=%b busy=%b expected 0 0 0", err, cmd_valid, busy);
      end
`endif
   endtask

   task automatic test_illegal();
      mode = 2'b11; cmd_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      n_cmp++;
      if ({err, cmd_valid, busy, done} !== 4'b1000) begin
         n_bad++;
         $display("FAIL illegal_err: got err=%b v=%b busy=%b done=%b expected 1 0 0 0", err, cmd_valid, busy, done);
      end
      step();
      n_cmp++;
      if ({err, cmd_valid, busy} !== 3'b000) begin
         n_bad++;
         $display("FAIL illegal_after: got err=%b v=%b busy=%b expected 0 0 0", err, cmd_valid, busy);
      end
   endtask

   task automatic test_mac_zero();
      mode = 2'b00; mac_len = 8'd0; cmd_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      n_cmp++;
      if ({done, cmd_valid, busy, err} !== 4'b1010) begin
         n_bad++;
         $display("FAIL mac_zero_done: got done=%b v=%b busy=%b err=%b expected 1 0 1 0", done, cmd_valid, busy, err);
      end
      step();
      n_cmp++;
      if ({done, cmd_valid, busy} !== 3'b000) begin
         n_bad++;
         $display("FAIL mac_zero_after: got done=%b v=%b busy=%b expected 0 0 0", done, cmd_valid, busy);
      end
   endtask

   task automatic test_abort();
      logic saw_done = 1'b0;
      mode = 2'b01; seed = 16'h0100; cmd_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 10; c++) step();
      // Eleventh command: index 10 -> bank 2, row 2.
      n_cmp++;
      if ({cmd_valid, addr, data_bank} !== {1'b1, 9'b0010_10_000, 16'h0104}) begin
         n_bad++;
         $display("FAIL abort_pre: got v=%b a=%h db=%h expected 1 050 0104", cmd_valid, addr, data_bank);
      end
      cmd_ready = 1'b0; abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      n_cmp++;
      if ({cmd_valid, op_code, addr, data_bank, busy, done} !== {1'b0, 2'b11, 9'd0, 16'd0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL abort_idle: got v=%b op=%b a=%h db=%h busy=%b done=%b expected idle NOP",
                  cmd_valid, op_code, addr, data_bank, busy, done);
      end
      for (int c = 0; c < 4; c++) begin
         if (done || cmd_valid) saw_done = 1'b1;
         step();
      end
      n_cmp++;
      if (saw_done !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_no_done: got activity=%b expected 0", saw_done);
      end
   endtask

   task automatic test_rst_mid_mac();
      logic saw = 1'b0;
      mode = 2'b00; seed = 16'h0042; mac_len = 8'd20; op_data = 16'h0F0F;
      cmd_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      n_cmp++;
      if ({cmd_valid, addr} !== {1'b1, 9'b0000_10_000}) begin
         n_bad++;
         $display("FAIL rst_pre: got v=%b a=%h expected 1 010", cmd_valid, addr);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({cmd_valid, op_code, addr, data_bank, data_in, busy, done} !==
          {1'b0, 2'b11, 9'd0, 16'd0, 16'd0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL rst_async: got v=%b op=%b a=%h db=%h di=%h busy=%b done=%b expected idle NOP",
                  cmd_valid, op_code, addr, data_bank, data_in, busy, done);
      end
      step();
      rst = 1'b0;
      for (int c = 0; c < 25; c++) begin
         if (done || cmd_valid || busy) saw = 1'b1;
         step();
      end
      n_cmp++;
      if (saw !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_no_done: got activity=%b expected 0", saw);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_mac();
      test_backpressure();
      test_cam();
      test_illegal();
      test_mac_zero();
      test_abort();
      test_rst_mid_mac();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
